// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with registered outputs and an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to build the restoring divider for div/divu (bits 14/15).

module seq_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH),
  parameter int CNT_WIDTH   = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [15:0]           alu_op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic [DATA_WIDTH-1:0] ResultHi,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero
);
  localparam int W = DATA_WIDTH;

  // Handshake: a request transfers on a rising edge with in_valid & in_ready (IDLE only);
  // a result transfers on out_valid & out_ready (DONE only); outputs are frozen in DONE.
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_e;
  state_e state_q, state_d;

  logic                 multi_sel, multi_signed;
  logic [W:0]           add_full, sub_full;
  logic                 add_ovf, sub_ovf, slt_bit, sltu_bit;
  logic [SHAMT_WIDTH-1:0] shamt;
  logic [W-1:0]         sra_val, sc_result;
  logic                 sc_ovf, sc_cout;
  logic [W-1:0]         mag_a, mag_b;

  logic [W-1:0]         hi_q, lo_q, opb_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 neg_res_q;
  logic [W:0]           mul_sum;
  logic [W-1:0]         step_hi, step_lo, fin_hi, fin_lo;
  logic [2*W-1:0]       prod, prod_neg;

  logic [W-1:0]         res_q, res_hi_q;
  logic                 ovf_q, cout_q, zero_q;

`ifdef SEQ_ALU_DIV_EN
  logic                 div_sel, div_q, neg_rem_q, b_zero_q;
  logic [W-1:0]         a_q;
  logic [W:0]           div_trial;
`else
  logic                 unused_div_ops;
  assign unused_div_ops = ^alu_op[15:14];
`endif

  // Multi-cycle op select: lowest set bit of [15:12] wins.
  always_comb begin
    multi_sel    = 1'b0;
    multi_signed = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    div_sel      = 1'b0;
`endif
    if (alu_op[12]) begin
      multi_sel    = 1'b1;
      multi_signed = 1'b1;
    end else if (alu_op[13]) begin
      multi_sel    = 1'b1;
`ifdef SEQ_ALU_DIV_EN
    end else if (alu_op[14]) begin
      multi_sel    = 1'b1;
      multi_signed = 1'b1;
      div_sel      = 1'b1;
    end else if (alu_op[15]) begin
      multi_sel    = 1'b1;
      div_sel      = 1'b1;
`endif
    end
  end

  assign add_full = {1'b0, A} + {1'b0, B};
  assign sub_full = {1'b0, A} - {1'b0, B};
  assign add_ovf  = (A[W-1] == B[W-1]) && (add_full[W-1] != A[W-1]);
  assign sub_ovf  = (A[W-1] != B[W-1]) && (sub_full[W-1] != A[W-1]);
  assign slt_bit  = $signed(A) < $signed(B);
  assign sltu_bit = A < B;
  assign shamt    = A[SHAMT_WIDTH-1:0];
  assign sra_val  = $signed(B) >>> shamt;

  // Several single-cycle bits set: results are ORed together, flags likewise.
  always_comb begin
    sc_result = '0;
    if (alu_op[0])  sc_result |= add_full[W-1:0];
    if (alu_op[1])  sc_result |= sub_full[W-1:0];
    if (alu_op[2])  sc_result |= {{(W-1){1'b0}}, slt_bit};
    if (alu_op[3])  sc_result |= {{(W-1){1'b0}}, sltu_bit};
    if (alu_op[4])  sc_result |= A & B;
    if (alu_op[5])  sc_result |= ~(A | B);
    if (alu_op[6])  sc_result |= A | B;
    if (alu_op[7])  sc_result |= A ^ B;
    if (alu_op[8])  sc_result |= B << shamt;
    if (alu_op[9])  sc_result |= B >> shamt;
    if (alu_op[10]) sc_result |= sra_val;
    if (alu_op[11]) sc_result |= {B[W/2-1:0], {(W/2){1'b0}}};
  end

  assign sc_ovf  = (alu_op[0] & add_ovf) | (alu_op[1] & sub_ovf);
  assign sc_cout = (alu_op[0] & add_full[W]) | (alu_op[1] & sub_full[W]);
  assign mag_a   = (multi_signed && A[W-1]) ? -A : A;
  assign mag_b   = (multi_signed && B[W-1]) ? -B : B;

  // One iteration: hi_q holds the partial product / remainder, lo_q the multiplier / quotient.
  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
    step_hi = mul_sum[W:1];
    step_lo = {mul_sum[0], lo_q[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
    div_trial = {hi_q, lo_q[W-1]} - {1'b0, opb_q};
    if (div_q) begin
      step_lo = {lo_q[W-2:0], ~div_trial[W]};
      step_hi = div_trial[W] ? {hi_q[W-2:0], lo_q[W-1]} : div_trial[W-1:0];
    end
`endif
  end

  // Sign fixup applied on the last iteration.
  always_comb begin
    prod     = {step_hi, step_lo};
    prod_neg = -prod;
    fin_hi   = neg_res_q ? prod_neg[2*W-1:W] : prod[2*W-1:W];
    fin_lo   = neg_res_q ? prod_neg[W-1:0]   : prod[W-1:0];
`ifdef SEQ_ALU_DIV_EN
    if (div_q) begin
      if (b_zero_q) begin
        fin_lo = '1;
        fin_hi = a_q;
      end else begin
        fin_lo = neg_res_q ? -step_lo : step_lo;
        fin_hi = neg_rem_q ? -step_hi : step_hi;
      end
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = multi_sel ? BUSY : DONE;
      BUSY:    if (cnt_q == CNT_WIDTH'(1)) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q      <= '0;
      lo_q      <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      neg_res_q <= 1'b0;
      res_q     <= '0;
      res_hi_q  <= '0;
      ovf_q     <= 1'b0;
      cout_q    <= 1'b0;
      zero_q    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      b_zero_q  <= 1'b0;
      a_q       <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          if (multi_sel) begin
            hi_q      <= '0;
            lo_q      <= mag_a;
            opb_q     <= mag_b;
            cnt_q     <= CNT_WIDTH'(W);
            neg_res_q <= multi_signed & (A[W-1] ^ B[W-1]);
`ifdef SEQ_ALU_DIV_EN
            div_q     <= div_sel;
            neg_rem_q <= multi_signed & A[W-1];
            b_zero_q  <= (B == '0);
            a_q       <= A;
`endif
          end else begin
            res_q    <= sc_result;
            res_hi_q <= '0;
            ovf_q    <= sc_ovf;
            cout_q   <= sc_cout;
            zero_q   <= (sc_result == '0);
          end
        end
        BUSY: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q - CNT_WIDTH'(1);
          if (cnt_q == CNT_WIDTH'(1)) begin
            res_q    <= fin_lo;
            res_hi_q <= fin_hi;
            ovf_q    <= 1'b0;
            cout_q   <= 1'b0;
            zero_q   <= (fin_lo == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign Result   = res_q;
  assign ResultHi = res_hi_q;
  assign Overflow = ovf_q;
  assign CarryOut = cout_q;
  assign Zero     = zero_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed and randomized checks of seq_alu against an arithmetic reference model.
// Build with SEQ_ALU_DIV_EN defined to cover the divider.

module tb_seq_alu;
  localparam int W = 32;
`ifdef SEQ_ALU_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          in_valid, in_ready, out_valid, out_ready;
  logic [15:0]   alu_op;
  logic [W-1:0]  a, b, result, result_hi;
  logic          overflow, carry_out, zero;

  logic          in_valid16, in_ready16, out_valid16, out_ready16;
  logic [15:0]   op16, a16, b16, res16, res_hi16;
  logic          ovf16, cout16, zero16;

  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .alu_op(alu_op),
    .A(a), .B(b), .out_valid(out_valid), .out_ready(out_ready), .Result(result),
    .ResultHi(result_hi), .Overflow(overflow), .CarryOut(carry_out), .Zero(zero)
  );

  seq_alu #(.DATA_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16), .alu_op(op16),
    .A(a16), .B(b16), .out_valid(out_valid16), .out_ready(out_ready16), .Result(res16),
    .ResultHi(res_hi16), .Overflow(ovf16), .CarryOut(cout16), .Zero(zero16)
  );

  // scoreboard
  int n_vec = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // reference model: plain wide arithmetic on the operation definitions
  task automatic model(input logic [15:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] lo, output logic [W-1:0] hi,
                       output logic ovf, output logic cout, output int lat);
    longint sx, sy, s, q, r;
    logic [63:0] p;
    logic [32:0] t;
    logic signed [W-1:0] ys;
    logic [W-1:0] tmp;
    int sel;
    sx = $signed(x);
    sy = $signed(y);
    ys = y;
    lo = '0; hi = '0; ovf = 1'b0; cout = 1'b0; lat = 1; sel = -1;
    for (int i = 12; i < 16; i++)
      if (op[i] && sel < 0 && (i < 14 || DIV_EN)) sel = i;
    case (sel)
      12: begin p = sx * sy; {hi, lo} = p; lat = W + 1; end
      13: begin p = {32'h0, x} * {32'h0, y}; {hi, lo} = p; lat = W + 1; end
      14: begin
        lat = W + 1;
        if (y == 0) begin lo = '1; hi = x; end
        else begin q = sx / sy; r = sx % sy; lo = q[31:0]; hi = r[31:0]; end
      end
      15: begin
        lat = W + 1;
        if (y == 0) begin lo = '1; hi = x; end
        else begin lo = x / y; hi = x % y; end
      end
      default: begin
        if (op[0]) begin
          lo |= x + y; s = sx + sy; ovf |= (longint'(int'(s)) != s);
          t = {1'b0, x} + {1'b0, y}; cout |= t[32];
        end
        if (op[1]) begin
          lo |= x - y; s = sx - sy; ovf |= (longint'(int'(s)) != s);
          cout |= (x < y);
        end
        if (op[2])  lo |= {31'h0, (sx < sy)};
        if (op[3])  lo |= {31'h0, (x < y)};
        if (op[4])  lo |= x & y;
        if (op[5])  lo |= ~(x | y);
        if (op[6])  lo |= x | y;
        if (op[7])  lo |= x ^ y;
        if (op[8])  lo |= y << x[4:0];
        if (op[9])  lo |= y >> x[4:0];
        if (op[10]) begin tmp = ys >>> x[4:0]; lo |= tmp; end
        if (op[11]) lo |= {y[15:0], 16'h0};
      end
    endcase
  endtask

  // driver: present a request at the negedge and drop it after the accepting edge
  task automatic drive_req(input logic [15:0] op, input logic [W-1:0] x, input logic [W-1:0] y);
    for (int k = 0; k < 100 && !in_ready; k++) @(negedge clk);
    alu_op = op; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
  endtask

  task automatic run_op(input logic [15:0] op, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
    logic [W-1:0] elo, ehi, qlo, qhi;
    logic eovf, ecout;
    int elat, lat;
    bit got, busy_ok, hold_ok;
    model(op, x, y, elo, ehi, eovf, ecout, elat);
    exp_q.push_back(elo);
    exp_q.push_back(ehi);
    drive_req(op, x, y);
    lat = 0; got = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    while (!got && lat < 3 * W) begin
      lat++;
      @(negedge clk);
      if (lat == 1) begin
        in_valid = 1'b0; a = $urandom; b = $urandom; alu_op = 16'($urandom);
      end
      if (in_ready) busy_ok = 1'b0;
      if (out_valid) got = 1'b1;
      else @(posedge clk);
    end
    qlo = exp_q.pop_front();
    qhi = exp_q.pop_front();
    check_eq("out_valid", got, 1'b1);
    check_eq("latency", lat, elat);
    check_eq("in_ready_low", busy_ok, 1'b1);
    check_eq("Result", result, qlo);
    check_eq("ResultHi", result_hi, qhi);
    check_eq("flags", {overflow, carry_out, zero}, {eovf, ecout, (qlo == 0)});
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (!out_valid || in_ready || result !== qlo || result_hi !== qhi || zero !== (qlo == 0))
        hold_ok = 1'b0;
    end
    check_eq("hold", hold_ok, 1'b1);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_handshake", {in_ready, out_valid}, 2'b10);
  endtask

  task automatic run16(input string tag, input logic [15:0] op, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] exp);
    @(negedge clk);
    op16 = op; a16 = x; b16 = y; in_valid16 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid16 = 1'b0;
    check_eq(tag, {out_valid16, res16}, {1'b1, exp});
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  function automatic logic [15:0] pick_op();
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4, 5: return 16'h1 << $urandom_range(0, 15);
      6:       return 16'($urandom_range(0, 4095));
      7:       return 16'h0;
      8:       return 16'($urandom);
      default: return (16'h1 << $urandom_range(12, 15)) | 16'($urandom_range(0, 4095));
    endcase
  endfunction

  initial begin
    bit quiet;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; a = '0; b = '0;
    in_valid16 = 1'b0; out_ready16 = 1'b1; op16 = '0; a16 = '0; b16 = '0;
    #1;
    check_eq("reset_state", {out_valid, in_ready, result, result_hi, overflow, carry_out, zero},
             {1'b0, 1'b1, 64'h0, 3'b000});
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_op(16'h0001, 32'h7FFF_FFFF, 32'h1, 0);
    run_op(16'h1000, 32'hFFFF_FFFD, 32'h7, 2);
    run_op(16'h0002, 32'h5, 32'h5, 4);
    run_op(16'h0000, 32'h1234, 32'h5678, 1);
    run_op(16'h0081, 32'h0F0F_0000, 32'h00FF_00FF, 0);
    run_op(16'h2003, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

    // reset while the multiplier is running: nothing may be emitted
    drive_req(16'h2000, 32'hDEAD_BEEF, 32'h1234_5678);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1 check_eq("rst_busy", {out_valid, in_ready, result}, {1'b0, 1'b1, 32'h0});
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) quiet = 1'b0;
    end
    check_eq("rst_no_output", quiet, 1'b1);
    run_op(16'h0400, 32'h4, 32'h8000_0000, 0);

    // reset while a result is waiting for the consumer
    drive_req(16'h0001, 32'h1, 32'h2);
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_before_rst", {out_valid, result}, {1'b1, 32'h3});
    #2 rst = 1'b1;
    #1 check_eq("rst_done", {out_valid, result, zero}, {1'b0, 32'h0, 1'b0});
    @(negedge clk);
    rst = 1'b0;

    run_op(16'h8000, 32'd100, 32'd7, 0);
    run_op(16'h4000, 32'h1234_5678, 32'h0, 0);
    run_op(16'h4000, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(16'h4000, 32'hFFFF_FFF9, 32'h2, 0);
    run_op(16'h8000, 32'hFFFF_FFFF, 32'h0, 1);

    for (int i = 0; i < 150; i++)
      run_op(pick_op(), pick(), pick(), $urandom_range(0, 3));

    run16("w16_slt", 16'h0004, 16'h8000, 16'h0001, 16'h0001);
    run16("w16_lui", 16'h0800, 16'h0000, 16'h00AB, 16'hAB00);
    run16("w16_sll", 16'h0100, 16'd15, 16'h0001, 16'h8000);
    run16("w16_add", 16'h0001, 16'hFFFF, 16'h0001, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
